// File: rtl/systolic_pkg.sv
// Shared types and helpers for the weight-stationary systolic PE.
// SYSTOLIC_PE_SAT_EN is the optional build macro; sat_add is used only when it is defined.
package systolic_pkg;

    localparam int BW_ACT_DEF  = 8;
    localparam int BW_WET_DEF  = 8;
    localparam int BW_ACCU_DEF = 32;

    typedef enum logic [1:0] {
        PE_MAC    = 2'b00,
        PE_BYPASS = 2'b01,
        PE_ZERO   = 2'b10,
        PE_WREAD  = 2'b11
    } pe_mode_e;

    // Adds two values that are already sign-extended to 64 bits.
    // The sum is clamped to the signed range of a w-bit accumulator.
    // Bit 64 of the result is the clamp flag; bits 63:0 hold the clamped sum.
    // Accumulators wider than 63 bits are not supported.
    function automatic logic [64:0] sat_add(input logic signed [63:0] a,
                                            input logic signed [63:0] b,
                                            input int unsigned w);
        logic signed [63:0] s;
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        s  = a + b;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        if (s > mx)      sat_add = {1'b1, mx};
        else if (s < mn) sat_add = {1'b1, mn};
        else             sat_add = {1'b0, s};
    endfunction

endpackage

// File: rtl/systolic_pe_wbuf.sv
// Weight buffer for one PE. It holds the shadow shift-chain register, the active
// weight and the swap FSM. A swap requested while the PE is stalled is held in
// PEND and committed on the first enabled cycle.
module systolic_pe_wbuf
    import systolic_pkg::*;
#(
    parameter int BW_WET = BW_WET_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     pe_en,
    input  logic signed [BW_WET-1:0] wet_in,
    input  logic                     wet_shift,
    input  logic                     wet_swap,
    input  logic                     wet_clear,
    output logic signed [BW_WET-1:0] w_act,
    output logic signed [BW_WET-1:0] wet_out
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [0:0]               state;
    logic signed [BW_WET-1:0] w_shd;

    assign wet_out = w_shd;

    // Clear wins over shift and swap. Swap reads the pre-shift shadow value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_act <= '0;
            w_shd <= '0;
            state <= ST_IDLE;
        end else if (wet_clear) begin
            w_act <= '0;
            w_shd <= '0;
            state <= ST_IDLE;
        end else begin
            if (pe_en && wet_shift)
                w_shd <= wet_in;
            case (state)
                ST_IDLE: begin
                    if (wet_swap) begin
                        if (pe_en) w_act <= w_shd;
                        else       state <= ST_PEND;
                    end
                end
                default: begin
                    if (pe_en) begin
                        w_act <= w_shd;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/systolic_array_pe_v2.sv
// Weight-stationary systolic PE. Activations move right and partial sums move
// down, with one register per hop. The mode mux selects MAC, BYPASS, ZERO or
// weight readback. Define SYSTOLIC_PE_SAT_EN for saturating MAC and a sat_flag port.
module systolic_array_pe_v2
    import systolic_pkg::*;
#(
    parameter int BW_ACT  = BW_ACT_DEF,
    parameter int BW_WET  = BW_WET_DEF,
    parameter int BW_ACCU = BW_ACCU_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      pe_en,
    input  logic [1:0]                mode,
    input  logic signed [BW_ACT-1:0]  act_in,
    input  logic                      act_vld_in,
    output logic signed [BW_ACT-1:0]  act_out,
    output logic                      act_vld_out,
    input  logic signed [BW_ACCU-1:0] psum_in,
    output logic signed [BW_ACCU-1:0] psum_out,
    output logic                      psum_vld_out,
    input  logic signed [BW_WET-1:0]  wet_in,
    input  logic                      wet_shift,
    output logic signed [BW_WET-1:0]  wet_out,
    input  logic                      wet_swap,
`ifdef SYSTOLIC_PE_SAT_EN
    input  logic                      wet_clear,
    output logic                      sat_flag
`else
    input  logic                      wet_clear
`endif
);

    localparam int PW = BW_ACT + BW_WET;

    if (BW_ACCU < PW) begin : g_width_chk
        $error("systolic_array_pe_v2: BW_ACCU must be >= BW_ACT+BW_WET");
    end

    logic signed [BW_WET-1:0]  w_act;
    logic signed [PW-1:0]      prod;
    logic signed [BW_ACCU-1:0] prod_ext;
    logic signed [BW_ACCU-1:0] w_ext;
    logic signed [BW_ACCU-1:0] psum_nxt;
    logic                      sat_nxt;

    systolic_pe_wbuf #(.BW_WET(BW_WET)) u_wbuf (
        .clk       (clk),
        .reset_n   (reset_n),
        .pe_en     (pe_en),
        .wet_in    (wet_in),
        .wet_shift (wet_shift),
        .wet_swap  (wet_swap),
        .wet_clear (wet_clear),
        .w_act     (w_act),
        .wet_out   (wet_out)
    );

    // Full-precision signed product. The size casts below sign-extend.
    assign prod     = PW'(act_in) * PW'(w_act);
    assign prod_ext = BW_ACCU'(prod);
    assign w_ext    = BW_ACCU'(w_act);

    // Mode mux computing the next partial sum and the clamp indication.
    always_comb begin
        psum_nxt = psum_in;
        sat_nxt  = 1'b0;
        case (pe_mode_e'(mode))
            PE_MAC: begin
                if (act_vld_in) begin
`ifdef SYSTOLIC_PE_SAT_EN
                    logic [64:0] r;
                    r        = sat_add(64'(psum_in), 64'(prod_ext), BW_ACCU);
                    psum_nxt = r[BW_ACCU-1:0];
                    sat_nxt  = r[64];
`else
                    psum_nxt = psum_in + prod_ext;
`endif
                end
            end
            PE_BYPASS: psum_nxt = psum_in;
            PE_ZERO:   psum_nxt = '0;
            default:   psum_nxt = w_ext;
        endcase
    end

    // One-hop pipeline registers. They hold while pe_en is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_out      <= '0;
            act_vld_out  <= 1'b0;
            psum_out     <= '0;
            psum_vld_out <= 1'b0;
        end else if (pe_en) begin
            act_out      <= act_in;
            act_vld_out  <= act_vld_in;
            psum_out     <= psum_nxt;
            psum_vld_out <= act_vld_in;
        end
    end

`ifdef SYSTOLIC_PE_SAT_EN
    // Clamp flag registered alongside psum_out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   sat_flag <= 1'b0;
        else if (pe_en) sat_flag <= sat_nxt;
    end
`else
    logic unused_sat;
    assign unused_sat = sat_nxt;
`endif

endmodule
